cache_line_fill: RTL and testbench

- AXI4 read-burst master that fills one instruction cache line into cache BRAM on a miss.
- Sits directly upstream of the fetch-side cache memory read logic. Takes a miss request (byte address) from it, bursts one line from the instruction AXI slave, writes each beat into the cache BRAM write port, then pulses DONE so fetch can retry.
- One outstanding line fill at a time.

---
 rtl/cache_line_fill.sv | 158 +++++++++++++++
 tb/tb_cache_line_fill.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill.sv
// Instruction-cache line fill: one AXI4 INCR read burst per miss, each beat written to the cache BRAM.
// Build option CACHE_LINE_FILL_ERR_CHECK_EN enables FILL_ERR (bad RRESP or misplaced RLAST).
//
// state  | meaning
// S_IDLE | waiting for FILL_REQ
// S_AR   | ARVALID high, holding ARADDR until ARREADY
// S_R    | RREADY high, writing one BRAM word per accepted beat
// S_DONE | FILL_DONE pulse; last BRAM write presented this cycle
module cache_line_fill #(
  parameter int          C_AXI_DATA_WIDTH = 32,
  parameter int          C_OFFSET_WIDTH   = 28,
  parameter logic [31:0] C_BASE_ADDR      = 32'h2000_0000,
  parameter int          LINE_WORDS       = 16,
  parameter int          BRAM_AW          = 11
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          FILL_REQ,
  input  logic [31:0]                   FILL_ADDR,
  output logic                          FILL_BUSY,
  output logic                          FILL_DONE,
  output logic                          FILL_ERR,
  output logic [31:0]                   ARADDR,
  output logic [7:0]                    ARLEN,
  output logic [2:0]                    ARSIZE,
  output logic [1:0]                    ARBURST,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                    RRESP,
  input  logic                          RLAST,
  input  logic                          RVALID,
  output logic                          RREADY,
  output logic [BRAM_AW-1:0]            BRAM_ADDR,
  output logic [C_AXI_DATA_WIDTH/8-1:0] BRAM_WREN,
  output logic [C_AXI_DATA_WIDTH-1:0]   BRAM_DIN
);

  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int OFF_LSB = LW_BITS + 2;
  localparam int LINE_W  = C_OFFSET_WIDTH - OFF_LSB;
  localparam int BEAT_W  = LW_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                          state_q;
  logic [LINE_W-1:0]               line_q;
  logic [BEAT_W-1:0]               beat_q;
  logic [31:0]                     araddr_q;
  logic                            arvalid_q;
  logic                            rready_q;
  logic                            busy_q;
  logic                            done_q;
  logic [BRAM_AW-1:0]              bram_addr_q;
  logic [BRAM_AW-1:0]              bram_addr_d;
  logic [C_AXI_DATA_WIDTH/8-1:0]   bram_wren_q;
  logic [C_AXI_DATA_WIDTH-1:0]     bram_din_q;
  logic [31:0]                     line_base_d;

  // Word address of the current beat; wraps inside the BRAM address space.
  assign bram_addr_d = BRAM_AW'({line_q, {LW_BITS{1'b0}}}) + BRAM_AW'(beat_q);
  assign line_base_d = 32'({FILL_ADDR[C_OFFSET_WIDTH-1:OFF_LSB], {OFF_LSB{1'b0}}});

`ifdef CACHE_LINE_FILL_ERR_CHECK_EN
  logic err_q;
  logic resp_err_q;
  logic unused_bits;
  assign FILL_ERR    = err_q;
  assign unused_bits = ^FILL_ADDR;
`else
  logic unused_bits;
  assign FILL_ERR    = 1'b0;
  assign unused_bits = ^{FILL_ADDR, RRESP};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      beat_q      <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bram_addr_q <= '0;
      bram_wren_q <= '0;
      bram_din_q  <= '0;
`ifdef CACHE_LINE_FILL_ERR_CHECK_EN
      err_q       <= 1'b0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      bram_wren_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (FILL_REQ) begin
            state_q   <= S_AR;
            busy_q    <= 1'b1;
            arvalid_q <= 1'b1;
            araddr_q  <= C_BASE_ADDR + line_base_d;
            line_q    <= FILL_ADDR[C_OFFSET_WIDTH-1:OFF_LSB];
            beat_q    <= '0;
`ifdef CACHE_LINE_FILL_ERR_CHECK_EN
            err_q      <= 1'b0;
            resp_err_q <= 1'b0;
`endif
          end
        end
        S_AR: begin
          if (ARREADY) begin
            state_q   <= S_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        S_R: begin
          if (RVALID) begin
            bram_wren_q <= '1;
            bram_din_q  <= RDATA;
            bram_addr_q <= bram_addr_d;
            beat_q      <= beat_q + 1'b1;
`ifdef CACHE_LINE_FILL_ERR_CHECK_EN
            if (RRESP != 2'b00) resp_err_q <= 1'b1;
            if (RLAST)
              err_q <= resp_err_q | (RRESP != 2'b00) | (beat_q != BEAT_W'(LINE_WORDS - 1));
`endif
            // RLAST, not the beat count, terminates the burst.
            if (RLAST) begin
              state_q  <= S_DONE;
              rready_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign FILL_BUSY = busy_q;
  assign FILL_DONE = done_q;
  assign ARADDR    = araddr_q;
  assign ARLEN     = 8'(LINE_WORDS - 1);
  assign ARSIZE    = 3'b010;
  assign ARBURST   = 2'b01;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign BRAM_ADDR = bram_addr_q;
  assign BRAM_WREN = bram_wren_q;
  assign BRAM_DIN  = bram_din_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: behavioural AXI read slave plus a BRAM-write scoreboard.
module tb_cache_line_fill;
  localparam int LW = 16;
  localparam int AW = 11;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FILL_REQ = 1'b0;
  logic [31:0]   FILL_ADDR = '0;
  logic          FILL_BUSY, FILL_DONE, FILL_ERR;
  logic [31:0]   ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARVALID, ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST, RVALID, RREADY;
  logic [AW-1:0] BRAM_ADDR;
  logic [3:0]    BRAM_WREN;
  logic [31:0]   BRAM_DIN;

  cache_line_fill dut (
    .CLK(CLK), .RST(RST), .FILL_REQ(FILL_REQ), .FILL_ADDR(FILL_ADDR),
    .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE), .FILL_ERR(FILL_ERR),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WREN(BRAM_WREN), .BRAM_DIN(BRAM_DIN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            req_cyc, done_cyc, done_cnt = 0, wr_cnt = 0, ar_cyc_cnt = 0;
  int            ar_wait = 0, gap_phase = 0, beat_idx = 0;
  int            rlast_beat = LW - 1;
  int            err_beat = -1;
  bit            gap_mode = 0, burst_active = 0, prev_done = 0, err_at_done = 0;
  logic [31:0]   exp_araddr = '0;
  logic [AW-1:0] exp_wbase = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Slave and monitor: everything is evaluated mid-cycle, so the handshake
  // at the following rising edge is known when the inputs are driven.
  initial begin
    wr_t e;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0; RLAST = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = '0;
        burst_active = 0; prev_done = 0;
      end else begin
        if (BRAM_WREN != 4'h0) begin
          wr_cnt++;
          n_checks++;
          if (BRAM_WREN !== 4'hF) begin
            n_errors++; $display("FAIL wren_value: got %h expected f", BRAM_WREN);
          end
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++; $display("FAIL unexpected_write: addr %0d data %h with nothing expected", BRAM_ADDR, BRAM_DIN);
          end else begin
            e = sb.pop_front();
            if (BRAM_ADDR !== e.addr || BRAM_DIN !== e.data) begin
              n_errors++;
              $display("FAIL bram_write: got addr %0d data %h expected addr %0d data %h", BRAM_ADDR, BRAM_DIN, e.addr, e.data);
            end
          end
        end
        if (prev_done) begin
          n_checks++;
          if (FILL_DONE !== 1'b0 || FILL_BUSY !== 1'b0) begin
            n_errors++; $display("FAIL after_done: done %b busy %b expected 0 0", FILL_DONE, FILL_BUSY);
          end
        end
        if (FILL_DONE) begin
          done_cnt++; done_cyc = cyc; err_at_done = FILL_ERR;
          n_checks++;
          if (FILL_BUSY !== 1'b1 || sb.size() != 0) begin
            n_errors++; $display("FAIL done_state: busy %b pending %0d expected busy 1 pending 0", FILL_BUSY, sb.size());
          end
        end
        prev_done = FILL_DONE;

        if (burst_active && RREADY) begin
          if (!gap_mode || gap_phase == 0) begin
            RVALID = 1; RDATA = $urandom();
            RLAST  = (beat_idx == rlast_beat);
            RRESP  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
            e.addr = exp_wbase + AW'(beat_idx);
            e.data = RDATA;
            sb.push_back(e);
            beat_idx++;
            if (RLAST) burst_active = 0;
          end else begin
            RVALID = 0; RLAST = 0; RRESP = 2'b00; RDATA = 32'hDEAD_BEEF;
          end
          gap_phase = (gap_phase + 1) % 3;
        end else begin
          RVALID = 0; RLAST = 0; RRESP = 2'b00;
        end

        if (ARVALID) begin
          ar_cyc_cnt++;
          n_checks++;
          if (ARADDR !== exp_araddr || ARLEN !== 8'd15 || ARSIZE !== 3'b010 || ARBURST !== 2'b01) begin
            n_errors++;
            $display("FAIL ar_channel: got addr %h len %0d size %b burst %b expected addr %h len 15 size 010 burst 01", ARADDR, ARLEN, ARSIZE, ARBURST, exp_araddr);
          end
          if (ar_wait > 0) begin
            ARREADY = 0; ar_wait--;
          end else begin
            ARREADY = 1; burst_active = 1; beat_idx = 0; gap_phase = 0;
          end
        end else begin
          ARREADY = 0;
        end
      end
    end
  end

  task automatic start_fill(input logic [31:0] a);
    logic [27:0] lb;
    lb = a[27:0] & ~28'h3F;
    exp_araddr = 32'h2000_0000 + {4'h0, lb};
    exp_wbase  = lb[12:2];
    wr_cnt = 0; ar_cyc_cnt = 0;
    @(negedge CLK);
    FILL_ADDR = a; FILL_REQ = 1; req_cyc = cyc;
    @(negedge CLK);
    FILL_REQ = 0;
  endtask

  task automatic wait_done(output bit timed_out);
    int start;
    start = done_cnt; timed_out = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK); #1;
      if (done_cnt != start) begin timed_out = 0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    #1;
    n_checks++;
    if ({ARVALID, RREADY, FILL_BUSY, FILL_DONE, FILL_ERR} !== 5'b0 || BRAM_WREN !== 4'h0) begin
      n_errors++; $display("FAIL reset_ctrl: got %b wren %h expected 00000 wren 0", {ARVALID, RREADY, FILL_BUSY, FILL_DONE, FILL_ERR}, BRAM_WREN);
    end
    n_checks++;
    if (ARADDR !== 32'h0 || BRAM_ADDR !== '0 || BRAM_DIN !== 32'h0) begin
      n_errors++; $display("FAIL reset_data: araddr %h bram_addr %0d din %h expected 0", ARADDR, BRAM_ADDR, BRAM_DIN);
    end
    RST = 0;
  endtask

  task automatic test_ready_slave();
    bit to;
    start_fill(32'h0000_0044);
    #1;
    n_checks++;
    if (FILL_BUSY !== 1'b1 || ARVALID !== 1'b1) begin
      n_errors++; $display("FAIL accept: busy %b arvalid %b expected 1 1", FILL_BUSY, ARVALID);
    end
    repeat (3) @(negedge CLK);
    FILL_ADDR = 32'h0123_4580; FILL_REQ = 1;
    @(negedge CLK);
    FILL_REQ = 0;
    wait_done(to);
    n_checks++;
    if (to !== 1'b0) begin n_errors++; $display("FAIL ready_timeout: done not seen expected done"); end
    n_checks++;
    if (wr_cnt != LW) begin n_errors++; $display("FAIL ready_writes: got %0d expected %0d", wr_cnt, LW); end
    n_checks++;
    if (done_cyc - req_cyc + 1 != LW + 3) begin
      n_errors++; $display("FAIL ready_latency: got %0d expected %0d", done_cyc - req_cyc + 1, LW + 3);
    end
    n_checks++;
    if (ar_cyc_cnt != 1) begin n_errors++; $display("FAIL ready_ar_cycles: got %0d expected 1", ar_cyc_cnt); end
  endtask

  task automatic test_stalled_ar();
    bit to;
    ar_wait = 5;
    start_fill(32'h0000_1000);
    wait_done(to);
    n_checks++;
    if (to !== 1'b0) begin n_errors++; $display("FAIL stall_timeout: done not seen expected done"); end
    n_checks++;
    if (ar_cyc_cnt != 6) begin n_errors++; $display("FAIL stall_ar_cycles: got %0d expected 6", ar_cyc_cnt); end
    n_checks++;
    if (wr_cnt != LW || done_cyc - req_cyc + 1 != LW + 8) begin
      n_errors++; $display("FAIL stall_fill: writes %0d latency %0d expected %0d %0d", wr_cnt, done_cyc - req_cyc + 1, LW, LW + 8);
    end
  endtask

  task automatic test_gapped_r();
    bit to;
    gap_mode = 1;
    start_fill(32'h0000_0200);
    wait_done(to);
    gap_mode = 0;
    n_checks++;
    if (to !== 1'b0) begin n_errors++; $display("FAIL gap_timeout: done not seen expected done"); end
    n_checks++;
    if (wr_cnt != LW || done_cyc - req_cyc + 1 != 3 * LW + 1) begin
      n_errors++; $display("FAIL gap_fill: writes %0d latency %0d expected %0d %0d", wr_cnt, done_cyc - req_cyc + 1, LW, 3 * LW + 1);
    end
  endtask

  task automatic test_addr_wrap();
    bit to;
    start_fill(32'h0FFF_FFC0);
    n_checks++;
    if (exp_araddr !== 32'h2FFF_FFC0 || exp_wbase !== 11'd2032) begin
      n_errors++; $display("FAIL wrap_model: got %h %0d expected 2fffffc0 2032", exp_araddr, exp_wbase);
    end
    wait_done(to);
    n_checks++;
    if (to !== 1'b0 || wr_cnt != LW) begin
      n_errors++; $display("FAIL wrap_fill: timeout %b writes %0d expected 0 %0d", to, wr_cnt, LW);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit to;
    start_fill(32'h0000_0400);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK); #1;
      if (wr_cnt >= 8) break;
    end
    RST = 1;
    #1;
    n_checks++;
    if ({ARVALID, RREADY, FILL_BUSY, FILL_DONE, FILL_ERR} !== 5'b0 || BRAM_WREN !== 4'h0 ||
        ARADDR !== 32'h0 || BRAM_ADDR !== '0 || BRAM_DIN !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset_outputs: ctrl %b wren %h araddr %h addr %0d din %h expected all 0", {ARVALID, RREADY, FILL_BUSY, FILL_DONE, FILL_ERR}, BRAM_WREN, ARADDR, BRAM_ADDR, BRAM_DIN);
    end
    sb.delete();
    repeat (2) @(negedge CLK);
    RST = 0;
    start_fill(32'h0000_0000);
    wait_done(to);
    n_checks++;
    if (to !== 1'b0 || wr_cnt != LW) begin
      n_errors++; $display("FAIL post_reset_fill: timeout %b writes %0d expected 0 %0d", to, wr_cnt, LW);
    end
  endtask

`ifdef CACHE_LINE_FILL_ERR_CHECK_EN
  task automatic test_err_flag();
    bit to;
    err_beat = 3;
    start_fill(32'h0000_0080);
    wait_done(to);
    err_beat = -1;
    n_checks++;
    if (to !== 1'b0 || err_at_done !== 1'b1) begin
      n_errors++; $display("FAIL err_resp: timeout %b err %b expected 0 1", to, err_at_done);
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (FILL_ERR !== 1'b1) begin n_errors++; $display("FAIL err_hold: got %b expected 1", FILL_ERR); end
    rlast_beat = 9;
    start_fill(32'h0000_00C0);
    #1;
    n_checks++;
    if (FILL_ERR !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %b expected 0", FILL_ERR); end
    wait_done(to);
    rlast_beat = LW - 1;
    n_checks++;
    if (to !== 1'b0 || err_at_done !== 1'b1 || wr_cnt != 10) begin
      n_errors++; $display("FAIL err_early_rlast: timeout %b err %b writes %0d expected 0 1 10", to, err_at_done, wr_cnt);
    end
    start_fill(32'h0000_0100);
    wait_done(to);
    n_checks++;
    if (to !== 1'b0 || err_at_done !== 1'b0) begin
      n_errors++; $display("FAIL err_clean_fill: timeout %b err %b expected 0 0", to, err_at_done);
    end
  endtask
`else
  task automatic test_err_flag();
    bit to;
    err_beat = 3;
    start_fill(32'h0000_0080);
    wait_done(to);
    err_beat = -1;
    n_checks++;
    if (to !== 1'b0 || err_at_done !== 1'b0 || FILL_ERR !== 1'b0) begin
      n_errors++; $display("FAIL err_disabled: timeout %b err %b expected 0 0", to, err_at_done);
    end
  endtask
`endif

  task automatic test_back_to_back();
    bit to1, to2;
    int d1;
    exp_araddr = 32'h2000_0800;
    exp_wbase  = 11'd512;
    wr_cnt = 0; ar_cyc_cnt = 0;
    @(negedge CLK);
    FILL_ADDR = 32'h0000_0800; FILL_REQ = 1;
    wait_done(to1);
    d1 = done_cyc;
    wait_done(to2);
    FILL_REQ = 0;
    n_checks++;
    if (to1 !== 1'b0 || to2 !== 1'b0) begin n_errors++; $display("FAIL b2b_timeout: %b %b expected 0 0", to1, to2); end
    n_checks++;
    if (done_cyc - d1 != LW + 3) begin
      n_errors++; $display("FAIL b2b_spacing: got %0d expected %0d", done_cyc - d1, LW + 3);
    end
    n_checks++;
    if (wr_cnt != 2 * LW || ar_cyc_cnt != 2) begin
      n_errors++; $display("FAIL b2b_counts: writes %0d ar %0d expected %0d 2", wr_cnt, ar_cyc_cnt, 2 * LW);
    end
    repeat (4) @(negedge CLK);
    #1;
    n_checks++;
    if (FILL_BUSY !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: busy %b expected 0", FILL_BUSY); end
  endtask

  initial begin
    test_reset();
    test_ready_slave();
    test_stalled_ar();
    test_gapped_r();
    test_addr_wrap();
    test_reset_mid_burst();
    test_err_flag();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
